// File: rtl/data_sram_arbiter_pkg.sv
// Shared types and constants for the data SRAM arbiter.
// Read-owner encodings, SRAM write-enable constants and parameter defaults.
package data_sram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } rd_owner_e;

    localparam logic [3:0] SRAM_WEN_READ = 4'b0000;
    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned CNT_W_DEF = 3;

    function automatic logic is_read(input logic [3:0] wen);
        return wen == SRAM_WEN_READ;
    endfunction

endpackage

// File: rtl/data_sram_arbiter_hold.sv
// Skid register that keeps a CPU load word alive across MEM-stage stalls.
// The first word returned while stalled is frozen until MEM moves on.
module sram_rdata_hold
    import data_sram_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd_cpu,
    input  logic        i_mem_stall,
    input  logic [31:0] i_sram_rdata,
    output logic [31:0] o_cpu_rdata
);

    logic        r_hold_valid;
    logic [31:0] r_hold_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (!i_mem_stall) begin
            r_hold_valid <= 1'b0;
        end else if (i_rd_cpu && !r_hold_valid) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= i_sram_rdata;
        end
    end

    assign o_cpu_rdata = r_hold_valid ? r_hold_data : i_sram_rdata;

endmodule

// File: rtl/data_sram_arbiter.sv
// Data SRAM arbiter: CPU-priority sharing with a DMA/debug master.
// A starvation counter forces DMA through after a bounded wait.
module data_sram_arbiter
    import data_sram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        mem_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stallreq,
    input  logic        dma_req,
    input  logic [3:0]  dma_wen,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata
);

    logic [CNT_W-1:0] r_starve_cnt;
    rd_owner_e        r_rd_owner;
    rd_owner_e        w_owner_nxt;
    logic             w_starved;
    logic             w_dma_gnt;
    logic             w_cpu_go;
    logic [31:0]      w_hold_rdata;

    // Everything combinational is gated by rst so outputs drop at once.
    assign w_starved = r_starve_cnt == CNT_W'(STARVE_MAX);
    assign w_dma_gnt = rst & dma_req & (~cpu_en | w_starved);
    assign w_cpu_go  = rst & cpu_en & ~w_dma_gnt;

    assign dma_gnt      = w_dma_gnt;
    assign cpu_stallreq = cpu_en & w_dma_gnt;

    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        unique case (1'b1)
            w_dma_gnt: begin
                data_sram_en    = 1'b1;
                data_sram_wen   = dma_wen;
                data_sram_addr  = dma_addr;
                data_sram_wdata = dma_wdata;
            end
            w_cpu_go: begin
                data_sram_en    = 1'b1;
                data_sram_wen   = cpu_wen;
                data_sram_addr  = cpu_addr;
                data_sram_wdata = cpu_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (w_dma_gnt || !dma_req) begin
            r_starve_cnt <= '0;
        end else if (!w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_comb begin
        w_owner_nxt = OWN_NONE;
        unique case (1'b1)
            w_dma_gnt && is_read(dma_wen): w_owner_nxt = OWN_DMA;
            w_cpu_go && is_read(cpu_wen):  w_owner_nxt = OWN_CPU;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_owner <= OWN_NONE;
        end else begin
            r_rd_owner <= w_owner_nxt;
        end
    end

    assign dma_rvalid = r_rd_owner == OWN_DMA;
    assign dma_rdata  = dma_rvalid ? data_sram_rdata : '0;

    sram_rdata_hold u_hold (
        .clk          (clk),
        .rst          (rst),
        .i_rd_cpu     (r_rd_owner == OWN_CPU),
        .i_mem_stall  (mem_stall),
        .i_sram_rdata (data_sram_rdata),
        .o_cpu_rdata  (w_hold_rdata)
    );

    assign cpu_rdata = rst ? w_hold_rdata : '0;

endmodule

// File: tb/tb_data_sram_arbiter.sv
// Directed bench for data_sram_arbiter with a behavioural SRAM.
// Returned read words are checked against a queue filled at issue time.
module tb_data_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        mem_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_stallreq;
    logic        dma_req;
    logic [3:0]  dma_wen;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    logic [31:0] z_cpu_rdata;
    logic        z_stallreq;
    logic        z_gnt;
    logic        z_rvalid;
    logic [31:0] z_rdata;
    logic        z_en;
    logic [3:0]  z_wen;
    logic [31:0] z_addr;
    logic [31:0] z_wdata;

    logic [31:0] mem [0:16383];
    logic [31:0] sram_q;
    logic        ovr_en;
    logic [31:0] dma_q[$];
    logic [31:0] cpu_q[$];
    int          n_cmp;
    int          n_err;

    assign data_sram_rdata = ovr_en ? 32'hFFFF_FFFF : sram_q;

    data_sram_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_wen(cpu_wen),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .mem_stall(mem_stall), .cpu_rdata(cpu_rdata),
        .cpu_stallreq(cpu_stallreq),
        .dma_req(dma_req), .dma_wen(dma_wen),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata)
    );

    data_sram_arbiter #(.STARVE_MAX(0), .CNT_W(3)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_wen(cpu_wen),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .mem_stall(mem_stall), .cpu_rdata(z_cpu_rdata),
        .cpu_stallreq(z_stallreq),
        .dma_req(dma_req), .dma_wen(dma_wen),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(z_gnt), .dma_rvalid(z_rvalid),
        .dma_rdata(z_rdata),
        .data_sram_en(z_en), .data_sram_wen(z_wen),
        .data_sram_addr(z_addr), .data_sram_wdata(z_wdata),
        .data_sram_rdata(data_sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        logic [31:0] w;
        if (data_sram_en) begin
            if (data_sram_wen == 4'b0000) begin
                sram_q <= mem[data_sram_addr[15:2]];
            end else begin
                w = mem[data_sram_addr[15:2]];
                for (int b = 0; b < 4; b++)
                    if (data_sram_wen[b])
                        w[8*b +: 8] = data_sram_wdata[8*b +: 8];
                mem[data_sram_addr[15:2]] <= w;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic pop_dma(input string tag);
        logic [31:0] e;
        if (dma_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s observed=dma_rvalid expected=no_pending_read", tag);
        end else begin
            e = dma_q.pop_front();
            chk(tag, dma_rdata, e);
        end
    endtask

    task automatic pop_cpu(input string tag);
        logic [31:0] e;
        if (cpu_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s observed=cpu_return expected=no_pending_read", tag);
        end else begin
            e = cpu_q.pop_front();
            chk(tag, cpu_rdata, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_en = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_wen = 0; dma_addr = 0; dma_wdata = 0;
        mem_stall = 0;
    endtask

    initial begin
        logic prev_go;
        n_cmp = 0;
        n_err = 0;
        clk = 0;
        rst = 0;
        ovr_en = 0;
        sram_q = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[32'h1000 >> 2] = 32'hDEAD_BEEF;
        mem[32'h2000 >> 2] = 32'h1234_5678;
        idle();
        cpu_en = 1;
        dma_req = 1;
        #12;
        chk("rst_gnt", {31'b0, dma_gnt}, 32'd0);
        chk("rst_en", {31'b0, data_sram_en}, 32'd0);
        chk("rst_stall", {31'b0, cpu_stallreq}, 32'd0);
        chk("rst_rvalid", {31'b0, dma_rvalid}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dma_rdata", dma_rdata, 32'd0);
        idle();
        #1 rst = 1;

        // idle CPU, DMA read
        tick();
        dma_req = 1; dma_wen = 4'b0000; dma_addr = 32'h1000;
        #1;
        chk("t1_gnt", {31'b0, dma_gnt}, 32'd1);
        chk("t1_stall", {31'b0, cpu_stallreq}, 32'd0);
        chk("t1_en", {31'b0, data_sram_en}, 32'd1);
        chk("t1_addr", data_sram_addr, 32'h1000);
        dma_q.push_back(32'hDEAD_BEEF);
        tick();
        chk("t1_rvalid", {31'b0, dma_rvalid}, 32'd1);
        pop_dma("t1_rdata");
        idle();
        tick();
        chk("t1_rvalid_off", {31'b0, dma_rvalid}, 32'd0);
        chk("t1_rdata_off", dma_rdata, 32'd0);

        // starvation with CPU loading every cycle
        prev_go = 0;
        for (int i = 0; i < 5; i++) begin
            cpu_en = 1; cpu_wen = 0; cpu_addr = 32'h2000;
            dma_req = 1; dma_wen = 4'hF;
            dma_addr = 32'h4000; dma_wdata = 32'hA5A5_A5A5;
            #1;
            chk($sformatf("t2_gnt_c%0d", i), {31'b0, dma_gnt},
                (i == 4) ? 32'd1 : 32'd0);
            chk($sformatf("t2_stall_c%0d", i), {31'b0, cpu_stallreq},
                (i == 4) ? 32'd1 : 32'd0);
            if (i != 4) cpu_q.push_back(32'h1234_5678);
            tick();
            if (i != 4) pop_cpu($sformatf("t2_cpu_rdata_c%0d", i));
            chk($sformatf("t2_rvalid_c%0d", i), {31'b0, dma_rvalid}, 32'd0);
        end
        chk("t2_cnt_c5", {29'b0, dut.r_starve_cnt}, 32'd0);
        #1;
        chk("t2_gnt_c5", {31'b0, dma_gnt}, 32'd0);
        idle();
        tick();

        // hold buffer across a MEM stall
        cpu_en = 1; cpu_wen = 0; cpu_addr = 32'h2000;
        #1;
        cpu_q.push_back(32'h1234_5678);
        tick();
        pop_cpu("t3_rdata_c1");
        mem_stall = 1;
        tick();
        ovr_en = 1;
        #1;
        chk("t3_hold_c2", cpu_rdata, 32'h1234_5678);
        tick();
        chk("t3_hold_c3", cpu_rdata, 32'h1234_5678);
        mem_stall = 0;
        cpu_en = 0;
        #1;
        chk("t3_hold_c4", cpu_rdata, 32'h1234_5678);
        tick();
        chk("t3_follow_c5", cpu_rdata, 32'hFFFF_FFFF);
        ovr_en = 0;
        idle();
        tick();

        // CPU store colliding with a forced DMA write
        for (int i = 0; i < 4; i++) begin
            cpu_en = 1; cpu_wen = 0; cpu_addr = 32'h2000;
            dma_req = 1; dma_wen = 4'hF;
            dma_addr = 32'h3000; dma_wdata = 32'h1122_3344;
            #1;
            cpu_q.push_back(32'h1234_5678);
            tick();
            pop_cpu($sformatf("t4_cpu_rdata_c%0d", i));
        end
        cpu_wen = 4'b0011; cpu_addr = 32'h3000; cpu_wdata = 32'hAAAA_BBBB;
        #1;
        chk("t4_gnt_c4", {31'b0, dma_gnt}, 32'd1);
        chk("t4_stall_c4", {31'b0, cpu_stallreq}, 32'd1);
        chk("t4_wen_c4", {28'b0, data_sram_wen}, 32'hF);
        chk("t4_wdata_c4", data_sram_wdata, 32'h1122_3344);
        tick();
        dma_req = 0;
        #1;
        chk("t4_gnt_c5", {31'b0, dma_gnt}, 32'd0);
        chk("t4_stall_c5", {31'b0, cpu_stallreq}, 32'd0);
        chk("t4_wen_c5", {28'b0, data_sram_wen}, 32'h3);
        chk("t4_addr_c5", data_sram_addr, 32'h3000);
        chk("t4_wdata_c5", data_sram_wdata, 32'hAAAA_BBBB);
        tick();
        cpu_wen = 0;
        #1;
        cpu_q.push_back(32'h1122_BBBB);
        tick();
        pop_cpu("t4_merged");
        idle();
        tick();

        // asynchronous reset with a DMA read in flight and a held word
        cpu_en = 1; cpu_wen = 0; cpu_addr = 32'h2000;
        #1;
        cpu_q.push_back(32'h1234_5678);
        tick();
        pop_cpu("t5_cpu_rdata");
        cpu_en = 0; mem_stall = 1;
        dma_req = 1; dma_wen = 0; dma_addr = 32'h1000;
        #1;
        chk("t5_gnt", {31'b0, dma_gnt}, 32'd1);
        dma_q.push_back(32'hDEAD_BEEF);
        tick();
        chk("t5_rvalid", {31'b0, dma_rvalid}, 32'd1);
        pop_dma("t5_dma_rdata");
        chk("t5_hold", cpu_rdata, 32'h1234_5678);
        cpu_en = 1;
        #1 rst = 0;
        #1;
        chk("t5_rst_rvalid", {31'b0, dma_rvalid}, 32'd0);
        chk("t5_rst_en", {31'b0, data_sram_en}, 32'd0);
        chk("t5_rst_stall", {31'b0, cpu_stallreq}, 32'd0);
        chk("t5_rst_gnt", {31'b0, dma_gnt}, 32'd0);
        chk("t5_rst_cpu_rdata", cpu_rdata, 32'd0);
        idle();
        #1 rst = 1;
        #1;
        chk("t5_cnt", {29'b0, dut.r_starve_cnt}, 32'd0);
        chk("t5_follow", cpu_rdata, 32'hDEAD_BEEF);
        tick();
        chk("t5_rvalid_after", {31'b0, dma_rvalid}, 32'd0);
        chk("t5_follow_after", cpu_rdata, 32'hDEAD_BEEF);

        // STARVE_MAX=0 instance: DMA always wins
        for (int i = 0; i < 4; i++) begin
            cpu_en = 1; cpu_wen = 0; cpu_addr = 32'h2000;
            dma_req = 1; dma_wen = 0; dma_addr = 32'h1000;
            #1;
            chk($sformatf("t6_gnt_c%0d", i), {31'b0, z_gnt}, 32'd1);
            chk($sformatf("t6_stall_c%0d", i), {31'b0, z_stallreq}, 32'd1);
            tick();
        end
        idle();
        tick();

        chk("dma_q_empty", dma_q.size(), 32'd0);
        chk("cpu_q_empty", cpu_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_sram_arbiter.md
Name: data_sram_arbiter

Overview:
- Shares the single-port, synchronous data SRAM between two requesters: the CPU load/store path, which issues in EX and consumes read data in MEM, and a secondary DMA/debug master.
- CPU normally has priority. A saturating starvation counter forces a DMA grant after a bounded wait, and the CPU is stalled for that cycle.
- Holds CPU load data across MEM-stage stalls so the MEM stage never loses a read word.
- Sits between the EX/MEM stages and the data_sram_* top-level pins.

Parameters:
- STARVE_MAX, 4: consecutive cycles a pending DMA request may be refused before it is forced through. 0 means DMA always wins when requesting.
- CNT_W, 3: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- cpu_en  in  1  CPU access request this cycle (from EX)
- cpu_wen  in  4  CPU byte write enables; 0000 = read
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU store data, already lane-aligned
- mem_stall  in  1  MEM stage is held this cycle
- cpu_rdata  out  32  load word presented to MEM
- cpu_stallreq  out  1  CPU access refused this cycle; pipeline must hold and re-present it
- dma_req  in  1  DMA access request; held until granted
- dma_wen  in  4  DMA byte write enables; 0000 = read
- dma_addr  in  32  DMA byte address
- dma_wdata  in  32  DMA store data
- dma_gnt  out  1  DMA access issued this cycle
- dma_rvalid  out  1  DMA read data valid, one cycle after a read grant
- dma_rdata  out  32  DMA read data
- data_sram_en  out  1  SRAM enable
- data_sram_wen  out  4  SRAM byte write enables
- data_sram_addr  out  32  SRAM address
- data_sram_wdata  out  32  SRAM write data
- data_sram_rdata  in  32  SRAM read data, valid the cycle after en with wen=0

Behaviour:
- Arbitration is combinational per cycle:
  - dma_gnt = dma_req & (~cpu_en | starve_cnt==STARVE_MAX).
  - cpu_stallreq = cpu_en & dma_gnt.
  - cpu_go = cpu_en & ~dma_gnt.
- SRAM mux:
  - When dma_gnt, drive data_sram_en=1 and the DMA wen/addr/wdata.
  - Else when cpu_go, drive data_sram_en=1 and the CPU signals.
  - Else drive data_sram_en=0 with wen/addr/wdata = 0.
- Starvation counter starve_cnt[CNT_W]:
  - Reset value 0.
  - Set to 0 when dma_gnt or ~dma_req.
  - Increment when dma_req & ~dma_gnt, saturating at STARVE_MAX.
  - Worst-case DMA latency with the CPU continuously requesting is STARVE_MAX cycles; the grant comes in cycle STARVE_MAX+1.
- Read ownership:
  - rd_owner register with states NONE / CPU / DMA; reset value NONE.
  - Next value: DMA if dma_gnt & dma_wen==0; CPU if cpu_go & cpu_wen==0; otherwise NONE.
  - Writes never set an owner.
- DMA return:
  - dma_rvalid = (rd_owner==DMA).
  - dma_rdata = data_sram_rdata when dma_rvalid, else 0.
- CPU hold buffer:
  - hold_valid and hold_data[32]; reset values 0 and 0.
  - At a clock edge where rd_owner==CPU, mem_stall=1 and hold_valid=0: capture data_sram_rdata and set hold_valid=1.
  - At the first edge where mem_stall=0: clear hold_valid.
  - While hold_valid=1, hold_data is never overwritten, including when EX re-issues the same read during the stall.
  - cpu_rdata = hold_valid ? hold_data : data_sram_rdata.
- Re-issued CPU accesses during a stall are permitted. Reads are harmless and writes are idempotent. The block does no de-duplication.
- Simultaneous events:
  - DMA forced grant with a CPU store: the store is not performed; cpu_stallreq=1; it is repeated next cycle.
  - A CPU read returning while mem_stall rises: captured as above.
- Reset values (async, rst=0): every output and register 0 / NONE; data_sram_en=0.
- Reset mid-operation: any pending DMA read return is dropped (dma_rvalid=0) and the hold buffer is discarded.
- No internal pipelining of requests: latency from grant to SRAM is 0 cycles; read data arrives at +1.

Decomposition:
- Shared package / defines.vh gets:
  - rd_owner encodings OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_DMA=2'd2.
  - SRAM_WEN_READ=4'b0000.
  - STARVE_MAX default.
- One natural sub-module: sram_rdata_hold, containing the hold_valid/hold_data skid register and the cpu_rdata mux.

Test Plan:
- Idle CPU, DMA read of 0x1000 (SRAM word 0xDEADBEEF) -> dma_gnt=1 same cycle; dma_rvalid=1 and dma_rdata=0xDEADBEEF next cycle; cpu_stallreq=0.
- CPU loads every cycle, dma_req held from cycle 0, STARVE_MAX=4:
  - dma_gnt=0 in cycles 0-3 and =1 in cycle 4, with cpu_stallreq=1 only in cycle 4.
  - starve_cnt back to 0 in cycle 5.
- CPU load of 0x2000 (0x12345678) in cycle 0, mem_stall=1 in cycles 1-3, SRAM rdata changed to 0xFFFFFFFF in cycle 2:
  - cpu_rdata=0x12345678 in cycles 1-3.
  - Hold buffer cleared after cycle 4, the first cycle with mem_stall=0.
- CPU store with wen=0011 to 0x3000 collides with a forced DMA write (wen=1111):
  - SRAM sees the DMA write first and the CPU store the next cycle.
  - Final word reflects the CPU bytes [15:0] over the DMA data.
- Assert rst=0 asynchronously one cycle after a DMA read grant:
  - dma_rvalid, data_sram_en and cpu_stallreq all 0 immediately, before any clock edge.
  - After release, starve_cnt=0 and cpu_rdata follows data_sram_rdata.
- STARVE_MAX=0, CPU and DMA both requesting continuously -> dma_gnt=1 and cpu_stallreq=1 every cycle.
